nmr_scan_sched: RTL

NMR_SCAN_SCHED -- requirements
Module: nmr_scan_sched

---
 rtl/nmr_scan_sched.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nmr_scan_sched.sv
// nmr_scan_sched: runs NSCAN bitstream-engine scans, applies a fixed blanking
// window and an inter-scan delay, walks the phase-cycle index and guards
// each scan with a watchdog.
//
// Handshake with the bitstream engine: BS_START is a single-cycle pulse that
// launches one scan. BS_DONE is a level that is high whenever the engine is
// idle or finished. It is not trusted for BLANK_CYC cycles after the pulse,
// which gives the engine time to drop it. A scan completes on the first RUN
// cycle in which BS_DONE is sampled high.
module nmr_scan_sched #(
  parameter int LOOP_WIDTH = 16,
  parameter int DLY_WIDTH  = 32,
  parameter int PH_WIDTH   = 4,
  parameter int WDOG_WIDTH = 32,
  parameter int BLANK_CYC  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [LOOP_WIDTH-1:0] NSCAN,
  input  logic [DLY_WIDTH-1:0]  TR_DLY,
  input  logic [PH_WIDTH-1:0]   PH_CYC_LEN,
  input  logic [WDOG_WIDTH-1:0] WDOG_LIM,
  output logic                  BS_START,
  input  logic                  BS_DONE,
  output logic [PH_WIDTH-1:0]   PH_IDX,
  output logic [LOOP_WIDTH-1:0] SCAN_CNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    FIRE   = 3'd2,
    BLANK  = 3'd3,
    RUN    = 3'd4,
    TRWAIT = 3'd5,
    FIN    = 3'd6
  } state_t;

  localparam logic [3:0]            BLANK_LAST = 4'(BLANK_CYC - 1);
  localparam logic [LOOP_WIDTH-1:0] LOOP_ONE   = LOOP_WIDTH'(1);
  localparam logic [DLY_WIDTH-1:0]  DLY_ONE    = DLY_WIDTH'(1);
  localparam logic [PH_WIDTH-1:0]   PH_ONE     = PH_WIDTH'(1);
  localparam logic [WDOG_WIDTH-1:0] WD_ONE     = WDOG_WIDTH'(1);

  state_t state;
  state_t state_nxt;

  // Run parameters captured in ARM; the live inputs are ignored afterwards.
  logic [LOOP_WIDTH-1:0] nscan_q;
  logic [DLY_WIDTH-1:0]  tr_dly_q;
  logic [PH_WIDTH-1:0]   ph_len_q;
  logic [WDOG_WIDTH-1:0] wdog_q;

  // Per-state counters; each restarts from zero whenever its state is entered.
  logic [3:0]            blank_cnt;
  logic [WDOG_WIDTH-1:0] wd_cnt;
  logic [DLY_WIDTH-1:0]  tr_cnt;

  // Strobes from the next-state logic to the datapath registers.
  logic                  start_acc;
  logic                  scan_done;
  logic                  wd_expire;
  logic [LOOP_WIDTH-1:0] scan_inc;
  logic [PH_WIDTH-1:0]   ph_adv;

  assign state_dbg = state;

  // SCAN_CNT never exceeds the latched NSCAN, so the increment cannot wrap.
  assign scan_inc = SCAN_CNT + LOOP_ONE;

  // Phase index after the current scan completes; lengths 0 and 1 pin it at 0.
  always_comb begin
    ph_adv = '0;
    if (ph_len_q > PH_ONE) begin
      if (PH_IDX == ph_len_q - PH_ONE) begin
        ph_adv = '0;
      end else begin
        ph_adv = PH_IDX + PH_ONE;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; ABORT wins over every scheduling event in a busy state.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    scan_done = 1'b0;
    wd_expire = 1'b0;
    case (state)
      IDLE, FIN: begin
        if (START && !ABORT) begin
          state_nxt = ARM;
          start_acc = 1'b1;
        end
      end
      ARM: begin
        // Decide on the live NSCAN, which is the value being latched this cycle.
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (NSCAN == '0) begin
          state_nxt = FIN;
        end else begin
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        if (ABORT) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BLANK;
        end
      end
      BLANK: begin
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (blank_cnt == BLANK_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A done seen on the expiry cycle still counts as a completed scan.
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (BS_DONE) begin
          scan_done = 1'b1;
          if (scan_inc == nscan_q) begin
            state_nxt = FIN;
          end else if (tr_dly_q == '0) begin
            state_nxt = FIRE;
          end else begin
            state_nxt = TRWAIT;
          end
        end else if ((wdog_q != '0) && (wd_cnt == wdog_q - WD_ONE)) begin
          wd_expire = 1'b1;
          state_nxt = FIN;
        end
      end
      TRWAIT: begin
        if (ABORT) begin
          state_nxt = IDLE;
        end else if (tr_cnt == tr_dly_q - DLY_ONE) begin
          state_nxt = FIRE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BS_START <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      BS_START <= (state_nxt == FIRE);
      BUSY     <= (state_nxt != IDLE) && (state_nxt != FIN);
      DONE     <= (state_nxt == FIN);
    end
  end

  // Dwell counters for blanking, watchdog and inter-scan delay.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blank_cnt <= '0;
      wd_cnt    <= '0;
      tr_cnt    <= '0;
    end else begin
      if ((state == BLANK) && (state_nxt == BLANK)) begin
        blank_cnt <= blank_cnt + 4'd1;
      end else begin
        blank_cnt <= '0;
      end
      if ((state == RUN) && (state_nxt == RUN)) begin
        wd_cnt <= wd_cnt + WD_ONE;
      end else begin
        wd_cnt <= '0;
      end
      if ((state == TRWAIT) && (state_nxt == TRWAIT)) begin
        tr_cnt <= tr_cnt + DLY_ONE;
      end else begin
        tr_cnt <= '0;
      end
    end
  end

  // Capture the run parameters while in ARM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      nscan_q  <= '0;
      tr_dly_q <= '0;
      ph_len_q <= '0;
      wdog_q   <= '0;
    end else if (state == ARM) begin
      nscan_q  <= NSCAN;
      tr_dly_q <= TR_DLY;
      ph_len_q <= PH_CYC_LEN;
      wdog_q   <= WDOG_LIM;
    end
  end

  // Scan count, phase index and error flag; all hold across an abort.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SCAN_CNT <= '0;
      PH_IDX   <= '0;
      ERR      <= 1'b0;
    end else if (start_acc) begin
      SCAN_CNT <= '0;
      PH_IDX   <= '0;
      ERR      <= 1'b0;
    end else begin
      if (scan_done) begin
        SCAN_CNT <= scan_inc;
        PH_IDX   <= ph_adv;
      end
      if (wd_expire) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule
